// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request/response bundle for the shared adder arbiter
interface adder_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_operand_a;
  logic [NUM_REQ*WIDTH-1:0] req_operand_b;
  logic [NUM_REQ-1:0]       req_subtract;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_result;
  logic                     resp_carry;
  logic [ID_W-1:0]          resp_id;

  modport master (
    output req_valid, req_operand_a, req_operand_b, req_subtract, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_carry, resp_id
  );

  modport slave (
    input  req_valid, req_operand_a, req_operand_b, req_subtract, resp_ready,
    output req_ready, resp_valid, resp_result, resp_carry, resp_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder/subtractor among requesters
module adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic           clock,
  input logic           reset,
  adder_arbiter_if.slave bus
);

  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_carry_q, resp_carry_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;

  logic             can_accept;
  logic             grant_found;
  logic             transfer;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand_id;
  int               cand;
  logic [NUM_REQ-1:0] ready;

  logic [WIDTH-1:0] op_a [NUM_REQ];
  logic [WIDTH-1:0] op_b [NUM_REQ];
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sub;
  logic [WIDTH:0]   sum;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_a[g] = bus.req_operand_a[g*WIDTH +: WIDTH];
      assign op_b[g] = bus.req_operand_b[g*WIDTH +: WIDTH];
    end
  endgenerate

  // The response slot is free if empty or being drained on this same edge.
  assign can_accept = !resp_valid_q || bus.resp_ready;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_id     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(last_grant_q) + k) % NUM_REQ;
      cand_id = ID_W'(cand);
      if (!grant_found && bus.req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  assign transfer = grant_found && can_accept && !reset;

  always_comb begin
    ready = '0;
    if (transfer) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign sel_a   = op_a[grant_idx];
  assign sel_b   = op_b[grant_idx];
  assign sel_sub = bus.req_subtract[grant_idx];
  assign sum     = {1'b0, sel_a} + {1'b0, (sel_sub ? ~sel_b : sel_b)} + {{WIDTH{1'b0}}, sel_sub};

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_carry_d  = resp_carry_q;
    resp_id_d     = resp_id_q;
    last_grant_d  = last_grant_q;
    if (transfer) begin
      resp_valid_d  = 1'b1;
      resp_result_d = sum[WIDTH-1:0];
      resp_carry_d  = sum[WIDTH];
      resp_id_d     = grant_idx;
      last_grant_d  = grant_idx;
    end else if (bus.resp_ready) begin
      resp_valid_d  = 1'b0;
    end
  end

  // last_grant resets to the top index so requester 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_carry_q  <= 1'b0;
      resp_id_q     <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_carry_q  <= resp_carry_d;
      resp_id_q     <= resp_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_carry  = resp_carry_q;
  assign bus.resp_id     = resp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for the shared adder arbiter
module tb_adder_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  typedef struct packed {
    logic        carry;
    logic [1:0]  id;
    logic [31:0] result;
  } resp_t;

  logic clock;
  logic reset;

  adder_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NREQ)) bus ();

  adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NREQ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  resp_t exp_q[$];
  int    grant_log[$];
  int    lg_m = NREQ - 1;
  int    pops = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic resp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input int id);
    resp_t       m;
    logic [32:0] d;
    if (sub) begin
      d       = {1'b0, a} - {1'b0, b};
      m.carry = ~d[32];
    end else begin
      d       = {1'b0, a} + {1'b0, b};
      m.carry = d[32];
    end
    m.result = d[31:0];
    m.id     = 2'(id);
    return m;
  endfunction

  // Monitor: checks held responses against the scoreboard and grants against a rotating-priority model.
  always @(negedge clock) begin
    logic [3:0] exp_ready;
    int         win;
    int         idx;
    logic       ca;
    if (reset) begin
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    end else begin
      ca = (exp_q.size() == 0) || bus.resp_ready;
      if (exp_q.size() > 0) begin
        check("resp_valid",  64'(bus.resp_valid), 64'(1));
        check("resp_result", 64'(bus.resp_result), 64'(exp_q[0].result));
        check("resp_carry",  64'(bus.resp_carry), 64'(exp_q[0].carry));
        check("resp_id",     64'(bus.resp_id), 64'(exp_q[0].id));
        if (bus.resp_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end else begin
        check("resp_idle", 64'(bus.resp_valid), 64'(0));
      end
      exp_ready = '0;
      win       = -1;
      if (ca) begin
        for (int i = 0; i < NREQ; i++) begin
          idx = (lg_m + 1 + i) % NREQ;
          if (win < 0 && bus.req_valid[idx]) win = idx;
        end
      end
      if (win >= 0) exp_ready[win] = 1'b1;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      if (win >= 0) begin
        exp_q.push_back(model(bus.req_operand_a[win*WIDTH +: WIDTH],
                              bus.req_operand_b[win*WIDTH +: WIDTH],
                              bus.req_subtract[win], win));
        grant_log.push_back(win);
        lg_m = win;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    bit accepted = 1'b0;
    @(posedge clock);
    #1;
    bus.req_operand_a[i*WIDTH +: WIDTH] = a;
    bus.req_operand_b[i*WIDTH +: WIDTH] = b;
    bus.req_subtract[i] = sub;
    bus.req_valid[i]    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.req_ready[i]) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) check("send_timeout", 64'(0), 64'(1));
    @(posedge clock);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic expect_now(input string tag, input logic [31:0] r, input logic c, input logic [1:0] id);
    check({tag, "_valid"}, 64'(bus.resp_valid), 64'(1));
    check({tag, "_result"}, 64'(bus.resp_result), 64'(r));
    check({tag, "_carry"}, 64'(bus.resp_carry), 64'(c));
    check({tag, "_id"}, 64'(bus.resp_id), 64'(id));
  endtask

  initial begin
    int p0;
    logic [31:0] ra;
    logic [31:0] rb;
    reset             = 1'b1;
    bus.req_valid     = 4'b1111;
    bus.req_operand_a = '0;
    bus.req_operand_b = '0;
    bus.req_subtract  = '0;
    bus.resp_ready    = 1'b1;
    #2;
    check("reset_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("reset_resp_result", 64'(bus.resp_result), 64'(0));
    check("reset_resp_carry", 64'(bus.resp_carry), 64'(0));
    check("reset_resp_id", 64'(bus.resp_id), 64'(0));
    check("reset_req_ready", 64'(bus.req_ready), 64'(0));
    bus.req_valid = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(1);

    // Async reset while a response is being held
    bus.resp_ready = 1'b0;
    send(0, 32'd7, 32'd8, 1'b0);
    expect_now("hold_before_rst", 32'd15, 1'b0, 2'd0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    lg_m = NREQ - 1;
    #1;
    check("async_reset_valid", 64'(bus.resp_valid), 64'(0));
    @(posedge clock);
    #1;
    reset          = 1'b0;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b1111;
    @(negedge clock);
    check("rr_first_after_reset", 64'(bus.req_ready), 64'(4'b0001));
    @(posedge clock);
    #1;
    bus.req_valid = '0;
    idle(2);

    send(0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    expect_now("add_5_3", 32'h8, 1'b0, 2'd0);
    idle(1);
    send(2, 32'h3, 32'h5, 1'b1);
    expect_now("sub_3_5", 32'hFFFF_FFFE, 1'b0, 2'd2);
    send(2, 32'h5, 32'h3, 1'b1);
    expect_now("sub_5_3", 32'h2, 1'b1, 2'd2);
    send(1, 32'hFFFF_FFFF, 32'h1, 1'b0);
    expect_now("wrap_add", 32'h0, 1'b1, 2'd1);
    send(3, 32'h0, 32'h0, 1'b1);
    expect_now("sub_zero", 32'h0, 1'b1, 2'd3);
    idle(2);

    // All four requesters valid for 8 cycles
    for (int i = 0; i < NREQ; i++) begin
      ra = $urandom;
      rb = $urandom;
      bus.req_operand_a[i*WIDTH +: WIDTH] = ra;
      bus.req_operand_b[i*WIDTH +: WIDTH] = rb;
      bus.req_subtract[i] = 1'($urandom_range(0, 1));
    end
    grant_log.delete();
    p0 = pops;
    bus.req_valid = 4'b1111;
    repeat (8) @(posedge clock);
    #1;
    bus.req_valid = '0;
    check("rr_count", 64'(grant_log.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) check("rr_order", 64'(grant_log[i]), 64'(i % 4));
    end
    repeat (2) @(negedge clock);
    check("rr_no_bubble", 64'(pops - p0), 64'(8));
    idle(1);

    // Backpressure with two requesters contending
    bus.resp_ready = 1'b0;
    bus.req_operand_a[1*WIDTH +: WIDTH] = 32'd10;
    bus.req_operand_b[1*WIDTH +: WIDTH] = 32'd20;
    bus.req_subtract[1] = 1'b0;
    bus.req_operand_a[2*WIDTH +: WIDTH] = 32'd100;
    bus.req_operand_b[2*WIDTH +: WIDTH] = 32'd1;
    bus.req_subtract[2] = 1'b1;
    bus.req_valid = 4'b0110;
    @(negedge clock);
    check("bp_first_grant", 64'(bus.req_ready), 64'(4'b0010));
    @(posedge clock);
    #1;
    bus.req_valid[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("bp_ready_low", 64'(bus.req_ready), 64'(0));
      check("bp_frozen_result", 64'(bus.resp_result), 64'(32'd30));
      check("bp_frozen_id", 64'(bus.resp_id), 64'(1));
    end
    @(posedge clock);
    #1;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    check("bp_next_grant", 64'(bus.req_ready), 64'(4'b0100));
    @(posedge clock);
    #1;
    bus.req_valid = '0;
    expect_now("bp_req2", 32'd99, 1'b1, 2'd2);
    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one WIDTH-bit adder/subtractor among NUM_REQ requesters, e.g. the branch-target, load/store address and multi-cycle unit sequencers.
- Uses round-robin arbitration with a valid/ready handshake on every requester port.
- Holds each sum in a single-entry response register, tagged with the requester id, until the consumer accepts it.
- Sits between the core's control sequencers and the shared adder datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the requester id.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: requester i presents an operation.
- req_ready  output  NUM_REQ  bit i: requester i's operation is accepted this cycle.
- req_operand_a  input  NUM_REQ*WIDTH  slice i = operand_a of requester i.
- req_operand_b  input  NUM_REQ*WIDTH  slice i = operand_b of requester i.
- req_subtract  input  NUM_REQ  bit i: 1 = a-b, 0 = a+b.
- resp_valid  output  1  response register holds a result.
- resp_ready  input  1  consumer accepts the response this cycle.
- resp_result  output  WIDTH  registered sum or difference.
- resp_carry  output  1  carry-out of bit WIDTH-1; for subtract, 1 = no borrow.
- resp_id  output  ID_W  index of the requester that produced resp_result.

Behaviour:
- Reset (asynchronous, any cycle):
  - resp_valid=0, resp_result=0, resp_carry=0, resp_id=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - An in-flight response is discarded. No req_ready bit is asserted while reset is high.
- can_accept = !resp_valid || resp_ready. The response register is empty or draining this cycle, which gives pass-through at one result per cycle.
- Grant (combinational):
  - Search req_valid from index last_grant+1 upward, wrapping modulo NUM_REQ.
  - The first set bit wins: grant_idx.
  - req_ready = one-hot(grant_idx) when can_accept && |req_valid, else 0.
  - At most one req_ready bit is set in any cycle.
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer occurs when req_valid[i] && req_ready[i]. On the next rising edge:
  - resp_result = a + (sub ? ~b : b) + sub, computed at WIDTH+1 bits. The MSB goes to resp_carry and the low WIDTH bits go to resp_result.
  - resp_id = grant_idx, resp_valid = 1, last_grant = grant_idx.
- Latency: exactly 1 cycle from transfer to resp_valid.
- Without a transfer:
  - If resp_ready && resp_valid, then resp_valid becomes 0 next edge.
  - Otherwise the response register holds its value.
  - resp_result, resp_carry and resp_id stay stable while resp_valid && !resp_ready.
- Backpressure:
  - A requester keeps req_valid and its operands stable until it sees req_ready.
  - Unaccepted requests are never dropped.
- Fairness:
  - last_grant advances only on a transfer.
  - A continuously-valid requester waits at most NUM_REQ-1 transfers.
- Wrap-around: the arithmetic is modulo 2^WIDTH. Overflow sets only resp_carry; no exception is raised.
- Single requester: it is granted every cycle that can_accept is true.
- No valid requests: req_ready=0 and last_grant is unchanged.
- Simultaneous resp_ready and new transfer: the old response is consumed and the new one is loaded on the same edge. There is no bubble.

Test Plan:
- Reset pulse mid-response (resp_valid=1) -> resp_valid drops immediately, asynchronously. After release, req_valid=4'b1111 grants requester 0 first.
- req 0 only, a=0x0000_0005, b=0x0000_0003, add -> resp_result=0x8, carry=0, id=0, one cycle after the req_ready pulse.
- req 2 subtract, a=0x3, b=0x5 -> resp_result=0xFFFF_FFFE, carry=0. Then a=0x5, b=0x3 subtract -> 0x2, carry=1.
- Wrap-around add, a=0xFFFF_FFFF, b=0x1 -> resp_result=0x0, carry=1.
- req_valid=4'b1111 held for 8 cycles with resp_ready=1 -> grant order 0,1,2,3,0,1,2,3, one result per cycle, no bubbles.
- resp_ready=0 for 3 cycles with req_valid=4'b0110:
  - req_ready stays 0 after the first accept.
  - Response fields stay frozen.
  - When resp_ready=1, the next grant goes to requester 2 (requester 1 was accepted first).
